spi_master_gen: RTL

SPI_MASTER_GEN -- requirements
Module: spi_master_gen

---
 rtl/spi_master_gen.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/spi_master_gen.sv
// SPI master: one transaction of 1..SPI_MAXLEN bits, MSB-first, SPI modes 0-3, one-hot active-low chip selects.
// Define SPI_LOOPBACK_EN to add a loopback input that feeds internal MOSI back into the receive sampler.
module spi_master_gen #(
   parameter int SPI_MAXLEN = 32,
   parameter int NUM_CS     = 4,
   parameter int DIV_W      = 16
) (
   input  logic                          clk,
   input  logic                          sresetn,
   input  logic                          start_cmd,
   output logic                          spi_drv_rdy,
   output logic                          done,
   input  logic [$clog2(SPI_MAXLEN):0]   n_clks,
   input  logic [$clog2(NUM_CS)-1:0]     cs_sel,
   input  logic                          cpol,
   input  logic                          cpha,
   input  logic [DIV_W-1:0]              clk_div,
   input  logic [SPI_MAXLEN-1:0]         tx_data,
   output logic [SPI_MAXLEN-1:0]         rx_data,
   output logic [NUM_CS-1:0]             SS_N,
   output logic                          SCLK,
   output logic                          MOSI,
`ifdef SPI_LOOPBACK_EN
   input  logic                          loopback,
`endif
   input  logic                          MISO
);
   localparam int NW = $clog2(SPI_MAXLEN) + 1;
   localparam int CW = $clog2(NUM_CS);
   localparam int EW = NW + 1;

   typedef enum logic [1:0] {S_IDLE, S_LEAD, S_XFER, S_TRAIL} state_t;

   state_t                r_state;
   logic [NW-1:0]         r_n;
   logic                  r_cpha;
   logic [DIV_W-1:0]      r_div;
   logic [DIV_W-1:0]      r_cnt;
   logic [EW-1:0]         r_edge;
   logic [SPI_MAXLEN-1:0] r_tx;
   logic [SPI_MAXLEN-1:0] r_rx;
   logic [NUM_CS-1:0]     r_ss_n;
   logic                  r_sclk;
   logic                  r_mosi;
   logic                  r_rdy;
   logic                  r_done;

   logic                  w_valid;
   logic [DIV_W-1:0]      w_div;
   logic [NW-1:0]         w_shamt;
   logic [SPI_MAXLEN-1:0] w_txal;
   logic [EW-1:0]         w_last;
   logic [EW-1:0]         w_k;
   logic                  w_sample;
   logic                  w_miso;

   assign w_valid  = (n_clks != '0) && (n_clks <= NW'(SPI_MAXLEN)) &&
                     ({1'b0, cs_sel} < (CW+1)'(NUM_CS));
   assign w_div    = (clk_div == '0) ? DIV_W'(1) : clk_div;
   // Left-align the word so the next bit to send is always the register MSB.
   assign w_shamt  = NW'(SPI_MAXLEN) - n_clks;
   assign w_txal   = tx_data << w_shamt;
   assign w_last   = {r_n, 1'b0};
   assign w_k      = r_edge + EW'(1);
   // Odd edges are leading edges; cpha selects which parity samples.
   assign w_sample = w_k[0] ^ r_cpha;

`ifdef SPI_LOOPBACK_EN
   assign w_miso = loopback ? r_mosi : MISO;
`else
   assign w_miso = MISO;
`endif

   always_ff @(posedge clk or negedge sresetn) begin
      if (!sresetn) begin
         r_state <= S_IDLE;
         r_n     <= '0;
         r_cpha  <= 1'b0;
         r_div   <= '0;
         r_cnt   <= '0;
         r_edge  <= '0;
         r_tx    <= '0;
         r_rx    <= '0;
         r_ss_n  <= '1;
         r_sclk  <= 1'b0;
         r_mosi  <= 1'b0;
         r_rdy   <= 1'b1;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_sclk <= cpol;
               if (start_cmd && w_valid) begin
                  r_state <= S_LEAD;
                  r_n     <= n_clks;
                  r_cpha  <= cpha;
                  r_div   <= w_div;
                  r_cnt   <= w_div - DIV_W'(1);
                  r_edge  <= '0;
                  r_rx    <= '0;
                  r_ss_n  <= ~(NUM_CS'(1) << cs_sel);
                  r_rdy   <= 1'b0;
                  if (cpha) begin
                     r_mosi <= 1'b0;
                     r_tx   <= w_txal;
                  end else begin
                     r_mosi <= w_txal[SPI_MAXLEN-1];
                     r_tx   <= w_txal << 1;
                  end
               end
            end
            S_LEAD, S_XFER: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - DIV_W'(1);
               end else if (r_state == S_XFER && r_edge == w_last) begin
                  r_state <= S_TRAIL;
                  r_cnt   <= r_div - DIV_W'(1);
               end else begin
                  r_state <= S_XFER;
                  r_cnt   <= r_div - DIV_W'(1);
                  r_sclk  <= ~r_sclk;
                  r_edge  <= w_k;
                  if (w_sample) begin
                     r_rx <= {r_rx[SPI_MAXLEN-2:0], w_miso};
                  end else if (w_k != w_last) begin
                     r_mosi <= r_tx[SPI_MAXLEN-1];
                     r_tx   <= r_tx << 1;
                  end
               end
            end
            S_TRAIL: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - DIV_W'(1);
               end else begin
                  r_state <= S_IDLE;
                  r_ss_n  <= '1;
                  r_mosi  <= 1'b0;
                  r_rdy   <= 1'b1;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign spi_drv_rdy = r_rdy;
   assign done        = r_done;
   assign rx_data     = r_rx;
   assign SS_N        = r_ss_n;
   assign SCLK        = r_sclk;
   assign MOSI        = r_mosi;

endmodule
